prog_loader: RTL

//  Serial program loader: the transmit end of the 1-bit processor's instruction-load port.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_fifo.sv | 56 +++++
 rtl/prog_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and the state encoding for the serial program loader.
package prog_loader_pkg;

  localparam int INSTR_W    = 13;    // bits per instruction word
  localparam int MAX_INSTR  = 1000;  // instruction-memory depth of the target processor
  localparam int CNT_W      = 10;    // width of the word counters
  localparam int FIFO_DEPTH = 4;     // word buffer depth, power of 2
  localparam int RST_CYCLES = 2;     // proc_reset cycles before streaming
  localparam int BIT_W      = $clog2(INSTR_W);
  localparam int RC_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRES,
    S_PRIME,
    S_SHIFT,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/prog_loader_fifo.sv
// Small synchronous FIFO with first-word-fall-through output.
// A push on a full FIFO is taken only when a pop happens in the same cycle.
module prog_loader_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign dout    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: buffers instruction words, pulses the processor
// reset, then streams each word LSB-first one bit per clock with load_en high.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_instr,
  input  logic               wr_valid,
  input  logic [INSTR_W-1:0] wr_data,
  output logic               wr_ready,
  output logic               proc_reset,
  output logic               load_en,
  output logic               load_bit,
  output logic               busy,
  output logic               done,
  output logic               error
);

  state_t             state_reg;
  logic [CNT_W-1:0]   n_reg;
  logic [CNT_W-1:0]   acc_cnt_reg;
  logic [CNT_W-1:0]   sent_cnt_reg;
  logic [BIT_W-1:0]   bit_cnt_reg;
  logic [RC_W-1:0]    rst_cnt_reg;
  logic [INSTR_W-1:0] shift_reg;
  logic               proc_reset_reg, load_en_reg, load_bit_reg;
  logic               busy_reg, done_reg, error_reg;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [INSTR_W-1:0] fifo_dout;
  logic               accepting, last_bit, more_words, prime_go;
  logic [CNT_W-1:0]   sent_inc;

  // Words are accepted only during a load and never beyond the latched count.
  assign accepting  = (state_reg == S_PRES) || (state_reg == S_PRIME) || (state_reg == S_SHIFT);
  assign wr_ready   = !fifo_full && accepting && (acc_cnt_reg < n_reg);
  assign fifo_push  = wr_valid && wr_ready;
  assign fifo_flush = (state_reg == S_ERROR);

  assign last_bit   = (bit_cnt_reg == BIT_W'(INSTR_W - 1));
  assign sent_inc   = sent_cnt_reg + 1'b1;
  assign more_words = (sent_inc < n_reg);
  // Priming until full (or all words in) keeps short loads from underrunning.
  assign prime_go   = fifo_full || (acc_cnt_reg == n_reg);
  assign fifo_pop   = ((state_reg == S_PRIME) && prime_go) ||
                      ((state_reg == S_SHIFT) && last_bit && more_words && !fifo_empty);

  prog_loader_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (wr_data),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Load sequencer: state, counters and registered outputs move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      n_reg          <= '0;
      acc_cnt_reg    <= '0;
      sent_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      rst_cnt_reg    <= '0;
      shift_reg      <= '0;
      proc_reset_reg <= 1'b0;
      load_en_reg    <= 1'b0;
      load_bit_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (fifo_push) acc_cnt_reg <= acc_cnt_reg + 1'b1;
      case (state_reg)
        S_IDLE, S_ERROR: begin
          if (start) begin
            n_reg        <= num_instr;
            acc_cnt_reg  <= '0;
            sent_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            rst_cnt_reg  <= '0;
            proc_reset_reg <= 1'b1;
            if (num_instr > CNT_W'(MAX_INSTR)) begin
              state_reg <= S_ERROR;
              error_reg <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= S_PRES;
              error_reg <= 1'b0;
              busy_reg  <= 1'b1;
            end
          end
        end
        S_PRES: begin
          if (rst_cnt_reg == RC_W'(RST_CYCLES - 1)) begin
            proc_reset_reg <= 1'b0;
            if (n_reg == '0) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_PRIME;
            end
          end else begin
            rst_cnt_reg <= rst_cnt_reg + 1'b1;
          end
        end
        S_PRIME: begin
          if (prime_go) begin
            state_reg    <= S_SHIFT;
            load_en_reg  <= 1'b1;
            load_bit_reg <= fifo_dout[0];
            shift_reg    <= fifo_dout >> 1;
            bit_cnt_reg  <= '0;
          end
        end
        S_SHIFT: begin
          if (last_bit) begin
            sent_cnt_reg <= sent_inc;
            if (!more_words) begin
              state_reg    <= S_DONE;
              load_en_reg  <= 1'b0;
              load_bit_reg <= 1'b0;
              done_reg     <= 1'b1;
            end else if (fifo_empty) begin
              state_reg      <= S_ERROR;
              load_en_reg    <= 1'b0;
              load_bit_reg   <= 1'b0;
              proc_reset_reg <= 1'b1;
              busy_reg       <= 1'b0;
              error_reg      <= 1'b1;
            end else begin
              load_bit_reg <= fifo_dout[0];
              shift_reg    <= fifo_dout >> 1;
              bit_cnt_reg  <= '0;
            end
          end else begin
            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            load_bit_reg <= shift_reg[0];
            shift_reg    <= shift_reg >> 1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign proc_reset = proc_reset_reg;
  assign load_en    = load_en_reg;
  assign load_bit   = load_bit_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;

endmodule
